// File: rtl/serial_adder_fsm_pkg.sv
// ============================================================================
// Module   : serial_adder_fsm_pkg
// Brief    : Shared state encoding for the bit-serial adder/subtractor.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_adder_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_adder_fsm_fa.sv
// ============================================================================
// Module   : full_adder_cell
// Brief    : One-bit full adder used as the serial datapath slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder_fsm.sv
// ============================================================================
// Module   : serial_adder_fsm
// Brief    : Bit-serial add/subtract, one bit per clock, LSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder_fsm
    import serial_adder_fsm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ovf_int_q, ovf_int_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_carry;

    full_adder_cell u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Subtraction is A + ~B + ~borrow_in, so B and the carry are inverted at load.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        ovf_int_d = ovf_int_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = DONE;
                    sum_d   = acc_q;
                    cout_d  = carry_q;
                    ovf_d   = ovf_int_q;
                end else begin
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
                    carry_d = fa_carry;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        ovf_int_d = carry_q ^ fa_carry;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            ovf_int_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            ovf_int_q <= ovf_int_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_fsm.sv
// ============================================================================
// Module   : tb_serial_adder_fsm
// Brief    : Scoreboard bench for serial_adder_fsm at WIDTH 8, 2 and 16.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder_fsm;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start8, sub8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        start2, sub2, cin2, busy2, done2, cout2, ovf2;
    logic [1:0]  a2, b2, sum2;
    logic        start16, sub16, cin16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    serial_adder_fsm #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .ovf(ovf8)
    );

    serial_adder_fsm #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .cin(cin2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2),
        .cout(cout2), .ovf(ovf2)
    );

    serial_adder_fsm #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .sum(sum16),
        .cout(cout16), .ovf(ovf16)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q8[$];
    exp_t q2[$];
    exp_t q16[$];
    exp_t e8, e2, e16;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got done at cycle %0d expected none", name, cyc);
    endtask

    // Held-result model: what sum/cout/ovf must show while a run is in flight.
    logic [7:0] h_sum8;
    logic       h_cout8, h_ovf8;

    always @(negedge clk) begin
        if (rst) begin
            h_sum8  = 8'h00;
            h_cout8 = 1'b0;
            h_ovf8  = 1'b0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                unexpected("done8_unexpected");
            end else begin
                e8 = q8.pop_front();
                check("sum8", sum8, e8.sum[7:0]);
                check("cout8", cout8, e8.cout);
                check("ovf8", ovf8, e8.ovf);
                check("latency8", cyc, e8.due);
                check("busy8_in_done", busy8, 1'b0);
                h_sum8  = e8.sum[7:0];
                h_cout8 = e8.cout;
                h_ovf8  = e8.ovf;
            end
        end else if (busy8) begin
            check("hold_sum8", sum8, h_sum8);
            check("hold_cout8", cout8, h_cout8);
            check("hold_ovf8", ovf8, h_ovf8);
        end
    end

    always @(negedge clk) begin
        if (!rst && done2) begin
            if (q2.size() == 0) begin
                unexpected("done2_unexpected");
            end else begin
                e2 = q2.pop_front();
                check("sum2", sum2, e2.sum[1:0]);
                check("cout2", cout2, e2.cout);
                check("ovf2", ovf2, e2.ovf);
                check("latency2", cyc, e2.due);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done16) begin
            if (q16.size() == 0) begin
                unexpected("done16_unexpected");
            end else begin
                e16 = q16.pop_front();
                check("sum16", sum16, e16.sum);
                check("cout16", cout16, e16.cout);
                check("ovf16", ovf16, e16.ovf);
                check("latency16", cyc, e16.due);
            end
        end
    end

    // Accept edge is cyc+1; done is sampled at the negedge after edge cyc+WIDTH+2.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo, input bit push);
        exp_t e;
        @(negedge clk);
        a8 = a; b8 = b; sub8 = s; cin8 = c; start8 = 1'b1;
        if (push) begin
            e.sum = {8'h00, es}; e.cout = ec; e.ovf = eo; e.due = cyc + 10;
            q8.push_back(e);
        end
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((q8.size() != 0 || q2.size() != 0 || q16.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q8.size() != 0 || q2.size() != 0 || q16.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got %0d pending results expected 0",
                     q8.size() + q2.size() + q16.size());
            q8.delete(); q2.delete(); q16.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
        start2 = 0; sub2 = 0; cin2 = 0; a2 = 0; b2 = 0;
        start16 = 0; sub16 = 0; cin16 = 0; a16 = 0; b16 = 0;
        repeat (2) @(negedge clk);
        check("rst_sum8", sum8, 8'h00);
        check("rst_cout8", cout8, 1'b0);
        check("rst_ovf8", ovf8, 1'b0);
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        #2 rst = 1'b0;

        op8(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1); wait_idle();
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1); wait_idle();
        op8(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1); wait_idle();
        op8(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b1); wait_idle();
        op8(8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1); wait_idle();
        op8(8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b1); wait_idle();
        op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1); wait_idle();

        // A second start mid-run must be ignored.
        op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle();

        // Start held high: re-accepted on the first IDLE edge after DONE.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        e.sum = 16'h0003; e.cout = 1'b0; e.ovf = 1'b0; e.due = cyc + 10;
        q8.push_back(e);
        e.due = cyc + 21;
        q8.push_back(e);
        repeat (12) @(negedge clk);
        start8 = 1'b0;
        wait_idle();

        // Reset mid-run aborts with no done and clears outputs at once.
        op8(8'h55, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_sum8", sum8, 8'h00);
        check("abort_cout8", cout8, 1'b0);
        check("abort_ovf8", ovf8, 1'b0);
        check("abort_busy8", busy8, 1'b0);
        check("abort_done8", done8, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (12) @(negedge clk);
        op8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1); wait_idle();

        // Narrow and wide builds: max + 1 + cin.
        @(negedge clk);
        a2 = 2'b11; b2 = 2'b01; sub2 = 1'b0; cin2 = 1'b1; start2 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 1'b0; cin16 = 1'b1; start16 = 1'b1;
        e.sum = 16'h0001; e.cout = 1'b1; e.ovf = 1'b0; e.due = cyc + 4;
        q2.push_back(e);
        e.due = cyc + 18;
        q16.push_back(e);
        @(negedge clk);
        start2 = 1'b0; start16 = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no completion expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
